// File: rtl/conv_stream_kxk_pkg.sv
// Shared constants and width helpers for the streaming KxK convolution engine.
package conv_stream_kxk_pkg;

    localparam int CLAMP_RAW = 0;
    localparam int CLAMP_SAT = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Index/counter width that never collapses to zero bits.
    function automatic int bits_for(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    function automatic int acc_width(input int dw, input int cw, input int k);
        return dw + cw + clog2(k * k) + 1;
    endfunction

endpackage

// File: rtl/conv_row_delay.sv
// Enable-gated register line carrying partial sums from one kernel row to the next.
module conv_row_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = clk ^ reset ^ en;
            assign q = d;
        end else begin : g_line
            logic [W-1:0] sr [DEPTH];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
                end else if (en) begin
                    sr[0] <= d;
                    for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/conv_stream_kxk.sv
// Streaming KxK convolution: each accepted pixel is broadcast to a transposed MAC
// array whose rows are linked by delay lines so the last stage emits a full window sum.
module conv_stream_kxk
    import conv_stream_kxk_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int AW    = acc_width(DW, CW, K),
    parameter int CLAMP = CLAMP_RAW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DW-1:0]               in_pxl,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        coef_we,
    input  logic [bits_for(K*K)-1:0]    coef_addr,
    input  logic signed [CW-1:0]        coef_data,
    output logic                        coef_busy,
    output logic signed [AW-1:0]        out_pxl,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sof,
    output logic                        out_eol,
    output logic                        frame_done
);

    localparam int NC   = K * K;
    localparam int NACC = (NC > 1) ? NC - 1 : 1;
    localparam int CAW  = bits_for(NC);
    localparam int XW   = bits_for(IMG_W);
    localparam int YW   = bits_for(IMG_H);
    localparam int PW   = CW + DW + 1;
    localparam int CTR  = (K / 2) * K + (K / 2);
    localparam logic [CAW:0]         NC_V = (CAW + 1)'(NC);
    localparam logic signed [AW-1:0] PMAX = AW'((2 ** DW) - 1);

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          win_ok;
    logic          coef_wr;

    logic signed [CW-1:0] coef [NC];
    logic signed [AW-1:0] acc  [NACC];
    logic signed [AW-1:0] nxt  [NC];
    logic signed [AW-1:0] dl_q [K];
    logic signed [AW-1:0] res;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and a pending output is held unchanged until taken.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign col_last  = (col == XW'(IMG_W - 1));
    assign row_last  = (row == YW'(IMG_H - 1));
    assign win_ok    = (row >= YW'(K - 1)) && (col >= XW'(K - 1));
    assign coef_busy = (col != '0) || (row != '0);
    // A write landing on the first pixel of a frame would change coefficients mid-window.
    assign coef_wr   = coef_we && !coef_busy && !accept && ({1'b0, coef_addr} < NC_V);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NC; k++) coef[k] <= (k == CTR) ? CW'(1) : CW'(0);
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (coef_wr && coef_addr == CAW'(k)) coef[k] <= coef_data;
            end
        end
    end

    assign dl_q[0] = '0;

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_row
            if (gi > 0) begin : g_dl
                conv_row_delay #(
                    .DEPTH(IMG_W - K),
                    .W    (AW)
                ) u_dl (
                    .clk  (clk),
                    .reset(reset),
                    .en   (accept),
                    .d    (acc[gi*K-1]),
                    .q    (dl_q[gi])
                );
            end

            for (genvar gj = 0; gj < K; gj++) begin : g_col
                localparam int N = gi * K + gj;
                logic signed [AW-1:0] prev;
                logic signed [PW-1:0] prod;

                if (gj == 0) begin : g_head
                    assign prev = dl_q[gi];
                end else begin : g_link
                    assign prev = acc[N-1];
                end

                assign prod   = $signed({1'b0, in_pxl}) * coef[N];
                assign nxt[N] = prev + AW'(prod);

                // The final stage feeds the output register directly instead of its own reg.
                if (N < NC - 1) begin : g_reg
                    logic signed [AW-1:0] r;
                    always_ff @(posedge clk or negedge reset) begin
                        if (!reset)      r <= '0;
                        else if (accept) r <= nxt[N];
                    end
                    assign acc[N] = r;
                end
            end
        end

        if (NC == 1) begin : g_single
            assign acc[0] = '0;
        end
    endgenerate

    always_comb begin
        res = nxt[NC-1];
        if (CLAMP == CLAMP_SAT) begin
            if (nxt[NC-1][AW-1])       res = '0;
            else if (nxt[NC-1] > PMAX) res = PMAX;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col        <= '0;
            row        <= '0;
            out_pxl    <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && row_last && col_last;

            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + YW'(1);
                end else begin
                    col <= col + XW'(1);
                end
            end

            if (accept && win_ok) begin
                out_valid <= 1'b1;
                out_pxl   <= res;
                out_sof   <= (row == YW'(K - 1)) && (col == XW'(K - 1));
                out_eol   <= col_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eol   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_kxk.sv
// Bench for conv_stream_kxk on a 5x5 image with a 3x3 kernel, raw and clamped variants.
module tb_conv_stream_kxk;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int AW = 21;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [DW-1:0]        in_pxl = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 coef_we = 1'b0;
    logic [3:0]           coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic                 coef_busy;
    logic signed [AW-1:0] out_pxl;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 out_sof;
    logic                 out_eol;
    logic                 frame_done;

    logic                 c_in_ready, c_busy, c_valid, c_sof, c_eol, c_fd;
    logic signed [AW-1:0] c_pxl;

    conv_stream_kxk #(.IMG_W(W), .IMG_H(H), .K(K), .DW(DW), .CW(CW), .AW(AW), .CLAMP(0)) dut (
        .clk(clk), .reset(reset), .in_pxl(in_pxl), .in_valid(in_valid), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy),
        .out_pxl(out_pxl), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_eol(out_eol), .frame_done(frame_done)
    );

    conv_stream_kxk #(.IMG_W(W), .IMG_H(H), .K(K), .DW(DW), .CW(CW), .AW(AW), .CLAMP(1)) dut_c (
        .clk(clk), .reset(reset), .in_pxl(in_pxl), .in_valid(in_valid), .in_ready(c_in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(c_busy),
        .out_pxl(c_pxl), .out_valid(c_valid), .out_ready(out_ready), .out_sof(c_sof),
        .out_eol(c_eol), .frame_done(c_fd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0][CW-1:0] coef;
        logic               rnd;
        logic [8:0][AW-1:0] exp;
    } vec_t;

    vec_t               tbl [3];
    int                 id_exp [9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
    int                 c5_exp [9] = '{35, 40, 45, 60, 65, 70, 85, 90, 95};
    logic [8:0][AW-1:0] id_vec;
    logic [8:0][AW-1:0] c5_vec;
    logic [8:0][AW-1:0] cur_exp;
    logic [AW+1:0]      exp_q [$];
    logic [AW+1:0]      mon_e;
    int                 idx = 0;
    int                 m_r = 0;
    int                 m_c = 0;
    int                 total = 0;
    int                 bad = 0;
    int                 fd_cnt = 0;
    int                 out_cnt = 0;
    int                 fd0, o0;

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    function automatic longint clampv(input longint v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Scoreboard consumer: an output is taken on the edge after a valid&ready sample.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_done) fd_cnt++;
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0d with empty queue", out_pxl);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_pxl", $signed(out_pxl), $signed(mon_e[AW+1:2]));
                    chk("out_sof", out_sof, mon_e[1]);
                    chk("out_eol", out_eol, mon_e[0]);
                    chk("clamp_valid", c_valid, out_valid);
                    chk("clamp_pxl", $signed(c_pxl), clampv($signed(mon_e[AW+1:2])));
                end
            end
        end
    end

    task automatic note_accept();
        if (m_r >= K - 1 && m_c >= K - 1) begin
            exp_q.push_back({cur_exp[idx], (m_r == K - 1 && m_c == K - 1), (m_c == W - 1)});
            idx++;
        end
        if (m_c == W - 1) begin
            m_c = 0;
            if (m_r == H - 1) begin
                m_r = 0;
                idx = 0;
            end else begin
                m_r++;
            end
        end else begin
            m_c++;
        end
    endtask

    task automatic send_pixel(input int v, input bit rnd, input bit we);
        int tries;
        bit got;
        if (rnd && $urandom_range(0, 1) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b1;
        in_pxl    = v[DW-1:0];
        coef_we   = we;
        coef_addr = 4'd4;
        coef_data = 8'sd9;
        got   = 1'b0;
        tries = 0;
        while (!got && tries < 100) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                note_accept();
            end
            @(posedge clk);
            #1;
            coef_we = 1'b0;
            tries++;
        end
        in_valid = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: pixel %0d not accepted in %0d cycles", v, tries);
        end
    endtask

    task automatic send_range(input int lo, input int hi, input bit rnd, input bit we_first);
        for (int p = lo; p <= hi; p++) send_pixel(p, rnd, we_first && (p == lo));
    endtask

    task automatic write_coef(input int a, input logic [CW-1:0] d);
        coef_we   = 1'b1;
        coef_addr = a[3:0];
        coef_data = d;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic load_coefs(input logic [8:0][CW-1:0] cf);
        for (int k = 0; k < 9; k++) write_coef(k, cf[k]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic stall_seq();
        int n;
        n = 0;
        while (!out_valid && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_saw_valid", out_valid, 1);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_pxl", $signed(out_pxl), 7);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 9; k++) begin
            id_vec[k] = AW'(id_exp[k]);
            c5_vec[k] = AW'(c5_exp[k]);
        end
        tbl[0].coef = '0;
        tbl[0].coef[4] = 8'sd1;
        tbl[0].rnd = 1'b0;
        tbl[0].exp = id_vec;
        tbl[1].coef = '0;
        tbl[1].coef[0] = 8'sd1;
        tbl[1].coef[1] = 8'sd2;
        tbl[1].coef[2] = 8'sd1;
        tbl[1].coef[6] = -8'sd1;
        tbl[1].coef[7] = -8'sd2;
        tbl[1].coef[8] = -8'sd1;
        tbl[1].rnd = 1'b0;
        for (int k = 0; k < 9; k++) tbl[1].exp[k] = AW'(-40);
        tbl[2] = tbl[0];
        tbl[2].rnd = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pxl", out_pxl, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_coef_busy", coef_busy, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Identity, gradient kernel, identity with random input gaps.
        for (int t = 0; t < 3; t++) begin
            load_coefs(tbl[t].coef);
            cur_exp = tbl[t].exp;
            fd0 = fd_cnt;
            o0  = out_cnt;
            send_range(1, 25, tbl[t].rnd, 1'b0);
            drain();
            chk("frame_done_count", fd_cnt - fd0, 1);
            chk("out_count", out_cnt - o0, 9);
        end

        // Output stall plus a coefficient write colliding with the first pixel.
        cur_exp = id_vec;
        fd0 = fd_cnt;
        o0  = out_cnt;
        fork
            send_range(1, 25, 1'b0, 1'b1);
            stall_seq();
        join
        drain();
        chk("stall_frame_done", fd_cnt - fd0, 1);
        chk("stall_out_count", out_cnt - o0, 9);

        // Mid-frame write dropped, same write between frames lands.
        cur_exp = id_vec;
        send_range(1, 12, 1'b0, 1'b0);
        @(negedge clk);
        chk("busy_mid_frame", coef_busy, 1);
        @(posedge clk);
        #1;
        write_coef(4, 8'sd5);
        send_range(13, 25, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        chk("busy_idle", coef_busy, 0);
        @(posedge clk);
        #1;
        write_coef(4, 8'sd5);
        cur_exp = c5_vec;
        o0 = out_cnt;
        send_range(1, 25, 1'b0, 1'b0);
        drain();
        chk("c5_out_count", out_cnt - o0, 9);

        // Reset mid-frame, then two back-to-back frames with identity coefficients.
        send_range(1, 13, 1'b0, 1'b0);
        drain();
        reset = 1'b0;
        m_r = 0;
        m_c = 0;
        idx = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", coef_busy, 0);
        chk("midrst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cur_exp = id_vec;
        fd0 = fd_cnt;
        o0  = out_cnt;
        send_range(1, 25, 1'b0, 1'b0);
        send_range(1, 25, 1'b0, 1'b0);
        drain();
        chk("b2b_frame_done", fd_cnt - fd0, 2);
        chk("b2b_out_count", out_cnt - o0, 18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
